// File: rtl/hack_ram_pkg.sv
// ============================================================================
// Module  : hack_ram_pkg
// Brief   : Shared state encoding and default geometry for the clearable RAM.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package hack_ram_pkg;

  localparam int unsigned c_DATA_W = 16;
  localparam int unsigned c_ADDR_W = 12;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

endpackage

`default_nettype wire

// File: rtl/ram_clr_seq.sv
// ============================================================================
// Module  : ram_clr_seq
// Brief   : Sweeps every word of the array to zero after reset or on request.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_clr_seq
  import hack_ram_pkg::*;
#(
  parameter int ADDR_W = c_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] c_LAST_ADDR = '1;

  clr_state_e        r_state;
  clr_state_e        w_state_next;
  logic [ADDR_W-1:0] r_clr_addr;
  logic [ADDR_W-1:0] w_clr_addr_next;

  // Reset lands in CLEAR so the array is zeroed without resetting the memory itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= CLEAR;
      r_clr_addr <= '0;
    end else begin
      r_state    <= w_state_next;
      r_clr_addr <= w_clr_addr_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_clr_addr_next = r_clr_addr;
    case (r_state)
      IDLE: begin
        if (clear) begin
          w_state_next    = CLEAR;
          w_clr_addr_next = '0;
        end
      end
      CLEAR: begin
        if (r_clr_addr == c_LAST_ADDR) begin
          w_state_next    = IDLE;
          w_clr_addr_next = '0;
        end else begin
          w_clr_addr_next = r_clr_addr + 1'b1;
        end
      end
      default: begin
        w_state_next    = CLEAR;
        w_clr_addr_next = '0;
      end
    endcase
  end

  assign busy     = (r_state == CLEAR);
  assign clr_we   = busy;
  assign clr_addr = r_clr_addr;

endmodule

`default_nettype wire

// File: rtl/hack_ram_clr.sv
// ============================================================================
// Module  : hack_ram_clr
// Brief   : Single-port RAM with registered write-first read and a full-array clear.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hack_ram_clr
  import hack_ram_pkg::*;
#(
  parameter int DATA_W = c_DATA_W,
  parameter int ADDR_W = c_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  input  logic              clear,
  output logic [DATA_W-1:0] data_out,
  output logic              busy
);

  localparam int c_DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [c_DEPTH];
  logic [DATA_W-1:0] r_data_out;
  logic              w_busy;
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_user_we;

  ram_clr_seq #(
    .ADDR_W (ADDR_W)
  ) u_clr_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .busy     (w_busy),
    .clr_we   (w_clr_we),
    .clr_addr (w_clr_addr)
  );

  // A clear request in the same cycle as a load drops the load.
  assign w_user_we = !w_busy && load && !clear;

  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[w_clr_addr] <= '0;
    end else if (w_user_we) begin
      r_mem[address] <= data_in;
    end
  end

  // Output is forced to zero on any edge that leaves or enters the sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_out <= '0;
    end else if (w_busy || clear) begin
      r_data_out <= '0;
    end else if (load) begin
      r_data_out <= data_in;
    end else begin
      r_data_out <= r_mem[address];
    end
  end

  assign data_out = r_data_out;
  assign busy     = w_busy;

endmodule

`default_nettype wire
